// File: rtl/fetch_decode_unit_pkg.sv
// Shared instruction-format definitions for the fetch/decode front end,
// the control FSM, the ALU and the trace monitor.
package fetch_decode_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int RI_BIT  = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 23;
  localparam int RS_MSB  = 22;
  localparam int RS_LSB  = 19;
  localparam int RT_MSB  = 18;
  localparam int RT_LSB  = 15;
  localparam int IMM_MSB = 14;
  localparam int IMM_W   = 16;

  // op_type encodings shared with the control FSM and ALU.
  typedef enum logic [3:0] {
    OP_ALU    = 4'h0,
    OP_LOAD   = 4'h1,
    OP_STORE  = 4'h2,
    OP_BRANCH = 4'h3,
    OP_JUMP   = 4'h4,
    OP_NOP    = 4'hF
  } op_type_e;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [3:0]       op_type;
    logic             reg_imm;
    logic [3:0]       rd;
    logic [3:0]       rs;
    logic [3:0]       rt;
    logic [IMM_W-1:0] imm;
  } instr_fields_t;

  // Sign-extend the raw immediate field (bits IMM_MSB..0) to IMM_W bits.
  function automatic logic [IMM_W-1:0] sext_imm(input logic [IMM_MSB:0] raw);
    return {{(IMM_W-IMM_MSB-1){raw[IMM_MSB]}}, raw};
  endfunction

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Instruction-memory request/acknowledge bus.
interface fetch_decode_unit_if #(
  parameter int ADDR_W = 8
) ();
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_decode_unit_instr_field_decode.sv
// Purely combinational split of an instruction word into its fields.
module instr_field_decode
  import fetch_decode_unit_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output instr_fields_t      fields
);

  // Field extraction; immediate is sign-extended from its top bit.
  always_comb begin
    fields.op_type = ir[OP_MSB:OP_LSB];
    fields.reg_imm = ir[RI_BIT];
    fields.rd      = ir[RD_MSB:RD_LSB];
    fields.rs      = ir[RS_MSB:RS_LSB];
    fields.rt      = ir[RT_MSB:RT_LSB];
    fields.imm     = sext_imm(ir[IMM_MSB:0]);
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Instruction fetch with req/ack memory handshake, timeout abort, PC
// ownership (post-increment / branch load) and IR field decode.
module fetch_decode_unit
  import fetch_decode_unit_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_req,
  input  logic                pc_write,
  input  logic [ADDR_W-1:0]   pc_target,
  fetch_decode_unit_if.master imem,
  output logic                busy,
  output logic                instr_valid,
  output logic                fetch_err,
  output logic [ADDR_W-1:0]   pc_out,
  output logic [3:0]          op_type,
  output logic                reg_imm,
  output logic [3:0]          rd,
  output logic [3:0]          rs,
  output logic [3:0]          rt,
  output logic [IMM_W-1:0]    imm
);

  // Counter value on the last REQ cycle before the request is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pending_q;
  logic              pending_valid_q;
  logic [7:0]        cnt_q;
  logic [INSTR_W-1:0] ir_q;
  logic              instr_valid_q;
  logic              fetch_err_q;
  logic              accept;
  logic              load_ir;
  logic              abort;
  instr_fields_t     fields;

  // Next-state and per-cycle control strobes.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    state_d = state_q;
    accept  = 1'b0;
    load_ir = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      FETCH_IDLE: begin
        if (fetch_req) begin
          accept  = 1'b1;
          state_d = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        // An ack on the final counted cycle still wins over the timeout.
        if (imem.ack) begin
          load_ir = 1'b1;
          state_d = FETCH_IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          abort   = 1'b1;
          state_d = FETCH_IDLE;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every
    // register samples the pre-edge values of its neighbours.
    if (!rst_n) state_q <= FETCH_IDLE;
    else        state_q <= state_d;
  end

  // PC, deferred branch target and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      cnt_q           <= '0;
    end else if (state_q == FETCH_IDLE) begin
      cnt_q           <= '0;
      pending_valid_q <= 1'b0;
      if (pc_write) pc_q <= pc_target;
    end else if (load_ir || abort) begin
      // Request ends: apply the newest branch target, else increment on success.
      cnt_q           <= '0;
      pending_valid_q <= 1'b0;
      if (pc_write)             pc_q <= pc_target;
      else if (pending_valid_q) pc_q <= pending_q;
      else if (load_ir)         pc_q <= pc_q + 1'b1;
    end else begin
      // Request outstanding: PC frozen so imem_addr stays stable.
      cnt_q <= cnt_q + 8'd1;
      if (pc_write) begin
        pending_q       <= pc_target;
        pending_valid_q <= 1'b1;
      end
    end
  end

  // Instruction register, valid flag and timeout error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q          <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      fetch_err_q <= abort;
      if (accept) instr_valid_q <= 1'b0;
      if (load_ir) begin
        ir_q          <= imem.rdata;
        instr_valid_q <= 1'b1;
      end
    end
  end

  instr_field_decode u_decode (
    .ir     (ir_q),
    .fields (fields)
  );

  assign imem.req    = (state_q == FETCH_REQ);
  assign imem.addr   = pc_q;
  assign busy        = (state_q == FETCH_REQ);
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;
  assign pc_out      = pc_q;
  assign op_type     = fields.op_type;
  assign reg_imm     = fields.reg_imm;
  assign rd          = fields.rd;
  assign rs          = fields.rs;
  assign rt          = fields.rt;
  assign imm         = fields.imm;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed self-checking bench for fetch_decode_unit.
module tb_fetch_decode_unit;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fetch_req = 1'b0;
  logic              pc_write = 1'b0;
  logic [ADDR_W-1:0] pc_target = '0;
  logic              busy, instr_valid, fetch_err;
  logic [ADDR_W-1:0] pc_out;
  logic [3:0]        op_type, rd, rs, rt;
  logic              reg_imm;
  logic [15:0]       imm;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_decode_unit_if #(.ADDR_W(ADDR_W)) imem ();

  fetch_decode_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .pc_write    (pc_write),
    .pc_target   (pc_target),
    .imem        (imem),
    .busy        (busy),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err),
    .pc_out      (pc_out),
    .op_type     (op_type),
    .reg_imm     (reg_imm),
    .rd          (rd),
    .rs          (rs),
    .rt          (rt),
    .imm         (imm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fields(input string tag, input logic [3:0] e_op, input logic e_ri,
                              input logic [3:0] e_rd, input logic [3:0] e_rs,
                              input logic [3:0] e_rt, input logic [15:0] e_imm);
    check({tag, ".op"},  32'(op_type), 32'(e_op));
    check({tag, ".ri"},  32'(reg_imm), 32'(e_ri));
    check({tag, ".rd"},  32'(rd),      32'(e_rd));
    check({tag, ".rs"},  32'(rs),      32'(e_rs));
    check({tag, ".rt"},  32'(rt),      32'(e_rt));
    check({tag, ".imm"}, 32'(imm),     32'(e_imm));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req"},   32'(imem.req),    32'd0);
    check({tag, ".addr"},  32'(imem.addr),   32'd0);
    check({tag, ".busy"},  32'(busy),        32'd0);
    check({tag, ".valid"}, 32'(instr_valid), 32'd0);
    check({tag, ".err"},   32'(fetch_err),   32'd0);
    check({tag, ".pc"},    32'(pc_out),      32'd0);
    check_fields(tag, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000);
  endtask

  // Zero-wait fetch: fetch_req, then ack in the first REQ cycle.
  task automatic fetch_now(input logic [31:0] data);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    imem.ack = 1'b1;
    imem.rdata = data;
    tick();
    imem.ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    imem.ack = 1'b0;
    imem.rdata = '0;

    // Reset state
    #2;
    check_reset_outputs("reset");
    #10 rst_n = 1'b1;
    tick();
    check_reset_outputs("post_reset");

    // Zero-wait fetch of 0x1A812345
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("t1.req", 32'(imem.req), 32'd1);
    check("t1.busy", 32'(busy), 32'd1);
    check("t1.addr", 32'(imem.addr), 32'h0);
    imem.ack = 1'b1;
    imem.rdata = 32'h1A81_2345;
    tick();
    imem.ack = 1'b0;
    check("t1.valid", 32'(instr_valid), 32'd1);
    check("t1.req_low", 32'(imem.req), 32'd0);
    check("t1.busy_low", 32'(busy), 32'd0);
    check("t1.pc", 32'(pc_out), 32'h01);
    check_fields("t1", 4'h1, 1'b1, 4'h5, 4'h0, 4'h2, 16'h2345);

    // Negative immediate; valid drops while the new fetch is outstanding
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("t2.valid_clear", 32'(instr_valid), 32'd0);
    check("t2.addr", 32'(imem.addr), 32'h01);
    imem.ack = 1'b1;
    imem.rdata = 32'h0000_4000;
    tick();
    imem.ack = 1'b0;
    check("t2.valid", 32'(instr_valid), 32'd1);
    check("t2.pc", 32'(pc_out), 32'h02);
    check_fields("t2", 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 16'hC000);

    // Three wait states: req and addr stable for 4 cycles
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3.req%0d", i), 32'(imem.req), 32'd1);
      check($sformatf("t3.addr%0d", i), 32'(imem.addr), 32'h02);
      check($sformatf("t3.valid%0d", i), 32'(instr_valid), 32'd0);
      if (i == 3) begin
        imem.ack = 1'b1;
        imem.rdata = 32'h3F7F_FFFF;
      end
      tick();
    end
    imem.ack = 1'b0;
    check("t3.valid", 32'(instr_valid), 32'd1);
    check("t3.pc", 32'(pc_out), 32'h03);
    check_fields("t3", 4'h3, 1'b1, 4'hE, 4'hF, 4'hF, 16'hFFFF);

    // pc_write together with fetch_req: fetch uses the target
    fetch_req = 1'b1;
    pc_write = 1'b1;
    pc_target = 8'h40;
    tick();
    fetch_req = 1'b0;
    pc_write = 1'b0;
    check("t4.addr", 32'(imem.addr), 32'h40);
    imem.ack = 1'b1;
    imem.rdata = 32'h4800_0001;
    tick();
    imem.ack = 1'b0;
    check("t4.pc", 32'(pc_out), 32'h41);
    check_fields("t4", 4'h4, 1'b1, 4'h0, 4'h0, 4'h0, 16'h0001);

    // pc_write during REQ is deferred; a later write overwrites it
    pc_write = 1'b1;
    pc_target = 8'h05;
    tick();
    pc_write = 1'b0;
    check("t5.pc_load", 32'(pc_out), 32'h05);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    pc_write = 1'b1;
    pc_target = 8'h33;
    tick();
    pc_target = 8'h10;
    tick();
    pc_write = 1'b0;
    check("t5.addr_stable", 32'(imem.addr), 32'h05);
    check("t5.pc_stable", 32'(pc_out), 32'h05);
    check("t5.req", 32'(imem.req), 32'd1);
    imem.ack = 1'b1;
    imem.rdata = 32'h1A81_2345;
    tick();
    imem.ack = 1'b0;
    check("t5.pc", 32'(pc_out), 32'h10);

    // PC wrap from 0xFF
    pc_write = 1'b1;
    pc_target = 8'hFF;
    tick();
    pc_write = 1'b0;
    fetch_now(32'h1A81_2345);
    check("t6.pc_wrap", 32'(pc_out), 32'h00);
    check("t6.valid", 32'(instr_valid), 32'd1);

    // Ack on the last counted cycle still succeeds
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (i == TIMEOUT - 1) begin
        imem.ack = 1'b1;
        imem.rdata = 32'h0000_4000;
      end
      tick();
    end
    imem.ack = 1'b0;
    check("t7.valid", 32'(instr_valid), 32'd1);
    check("t7.err", 32'(fetch_err), 32'd0);
    check("t7.pc", 32'(pc_out), 32'h01);
    check_fields("t7", 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 16'hC000);

    // Timeout: no ack for TIMEOUT cycles
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    n = 0;
    while (imem.req && n < 40) begin
      n++;
      tick();
    end
    check("t8.req_cycles", 32'(n), 32'(TIMEOUT));
    check("t8.err_pulse", 32'(fetch_err), 32'd1);
    check("t8.busy", 32'(busy), 32'd0);
    check("t8.valid", 32'(instr_valid), 32'd0);
    check("t8.pc", 32'(pc_out), 32'h01);
    check_fields("t8", 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 16'hC000);
    tick();
    check("t8.err_one_cycle", 32'(fetch_err), 32'd0);
    imem.ack = 1'b1;
    imem.rdata = 32'hFFFF_FFFF;
    tick();
    imem.ack = 1'b0;
    check("t8.late_ack_valid", 32'(instr_valid), 32'd0);
    check("t8.late_ack_op", 32'(op_type), 32'h0);
    check("t8.late_ack_pc", 32'(pc_out), 32'h01);
    check("t8.late_ack_busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a request
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("t9.req_before", 32'(imem.req), 32'd1);
    #2;
    rst_n = 1'b0;
    imem.ack = 1'b1;
    imem.rdata = 32'h1A81_2345;
    #1;
    check_reset_outputs("t9");
    tick();
    imem.ack = 1'b0;
    rst_n = 1'b1;
    tick();
    check_reset_outputs("t9.after");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
